// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: 2-bit counter
// encoding and the default datapath width.
package branch_predictor_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function: step towards strong-taken
// on a taken outcome, towards strong-not-taken otherwise.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != CTR_SNT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch lookup, execute
// stage resolution with mispredict/redirect and saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int XLEN     = XLEN_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             UpdValidE,
    input  logic [XLEN-1:0]  PCE,
    input  logic             TakenE,
    input  logic [XLEN-1:0]  TargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];

    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                f_hit, u_hit;
    logic [1:0]          u_ctr_next;

    assign f_idx = PCF[IDX_BITS+1:2];
    assign f_tag = PCF[XLEN-1:IDX_BITS+2];
    assign u_idx = PCE[IDX_BITS+1:2];
    assign u_tag = PCE[XLEN-1:IDX_BITS+2];

    // Lookup reads registered state only, so a same-index update this cycle
    // is seen from the following cycle.
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        PredTakenF  = f_hit && ctr_q[f_idx][1];
        PredTargetF = PredTakenF ? target_q[f_idx] : (PCF + XLEN'(4));
    end

    always_comb begin
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        MispredictE = UpdValidE &&
                      ((TakenE != PredTakenE) || (TakenE && (PredTargetE != TargetE)));
        RedirectPCE = (UpdValidE && TakenE) ? TargetE : (PCE + XLEN'(4));
    end

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (TakenE),
        .ctr_o   (u_ctr_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (UpdValidE) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_next;
            end else if (TakenE) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= CTR_ALLOC;
            end
        end
    end

    // Tag and target need no reset; they are only trusted once valid is set.
    always_ff @(posedge clk) begin
        if (UpdValidE && TakenE) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= TargetE;
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (UpdValidE) begin
            if (branch_cnt_q != {CNT_W{1'b1}}) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (MispredictE && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign BranchCount = branch_cnt_q;
    assign MissCount   = miss_cnt_q;

endmodule
